alu_unit: RTL and testbench
===========================

# alu_unit

Two-stage integer execute unit for the out-of-order core. It accepts ready-operand operations from the reservation station and computes ALU, branch and jump results. Each result is held until the common data bus grants a broadcast slot, then published with its RoB tag. On RoB_clear, every in-flight operation is discarded.

## Interface
- RoB_BITS, `RoB_BITS from const.v, width of RoB tags
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset (0 = reset)
- rdy_in  input  1  global pause; when low, all state holds
- RoB_clear  input  1  synchronous flush (misprediction)
- in_valid  input  1  RS offers an operation
- in_ready  output  1  unit can accept this cycle
- in_op  input  6  {funct7 bit, funct3, class}; class 0 U, 1 I, 2 B, 3 R; 6'b111111 = JAL
- in_jalr  input  1  I-class operation is JALR
- in_vj, in_vk  input  32  operand values
- in_imm  input  32  immediate (already pc+imm for AUIPC)
- in_pc  input  32  instruction PC
- in_dest  input  RoB_BITS  RoB tag
- alu_ack  output  1  pulse: operation accepted; RS frees the entry
- cdb_valid  output  1  result available
- cdb_grant  input  1  bus takes result this cycle
- cdb_dest  output  RoB_BITS  tag
- cdb_value  output  32  rd value
- cdb_is_jump  output  1  B, JAL or JALR
- cdb_taken  output  1  control transfer taken
- cdb_target  output  32  redirect PC

## Operation
- **Accept:** an operation is accepted when in_valid && in_ready && rdy_in && !RoB_clear. alu_ack = that same condition, combinational.
- **Stage EX:** registers in_op, in_jalr, in_vj, in_vk, in_imm, in_pc and in_dest, and sets ex_valid.
- **Stage OUT:** stores the computed result and sets out_valid. cdb_* are driven directly from OUT.
- **Stage advance:**
  - OUT clears when cdb_grant && out_valid.
  - EX moves to OUT when !out_valid, or when OUT is being granted in the same cycle.
  - in_ready = !ex_valid || (EX moves this cycle).
- **I/R compute** (operand B = vk for R, imm for I):
  - 000: add; sub only when R and funct7 = 1.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when funct7 = 1.
  - 110: or.
  - 111: and.
  - Shift amount is operand B[4:0].
  - Arithmetic is modulo 2^32.
  - cdb_is_jump = 0, cdb_taken = 0, cdb_target = 0.
- **B:** funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010 and 011 give not-taken. cdb_value = 0, cdb_target = pc+imm, cdb_is_jump = 1.
- **JAL:** cdb_value = pc+4, cdb_target = pc+imm, cdb_taken = 1.
- **JALR:** cdb_value = pc+4, cdb_target = (vj+imm) & ~1, cdb_taken = 1.
- **U:** cdb_value = imm, no jump.
- **Flush:** RoB_clear at an edge clears ex_valid and out_valid. No accept and no ack happen in that cycle. A grant in the same cycle is ignored.
- **Reset:** all outputs are 0 except in_ready = 1. alu_ack = 0 because in_valid gates it.

## Timing
- Latency: accepted at edge N → cdb_valid after edge N+1 (2 cycles).
- Throughput: one operation per cycle while cdb_grant is held high.
- Backpressure: if OUT is not granted, EX fills, then in_ready drops. Accepting a new operation while EX holds one that cannot advance is forbidden.
- While cdb_valid = 1 and cdb_grant = 0, all cdb_* outputs stay stable.
- rdy_in low: no state change, alu_ack = 0. cdb_valid keeps its value, but a grant is not consumed.
- Reset asserted mid-operation clears everything asynchronously. After release, the first accept is possible on the first edge.

## Structure
- const.v holds RoB_BITS, the class codes (U/I/B/R/J), and the funct3 constants for ALU and branch operations.
- One sub-module, alu_core: purely combinational. Inputs are the EX registers; outputs are value, is_jump, taken and target.
- alu_unit itself contains only the pipeline registers and the handshake logic.

## Test plan
- ADD: in_op = {0,000,3}, vj = 5, vk = 7, dest = 3, grant held 1 → alu_ack in the accept cycle; 2 cycles later cdb_valid = 1, value = 12, dest = 3.
- SUB / SRA: R op with funct7 = 1, vj = 0x80000000, vk = 4 → value 0x7FFFFFFC for sub, 0xF8000000 for sra.
- BLT: vj = -1, vk = 1, pc = 0x100, imm = 0x20 → taken = 1, target = 0x120. Same operands with BLTU → taken = 0.
- JALR: vj = 0x1003, imm = 4, pc = 0x40 → value 0x44, target 0x1006.
- Backpressure: grant held 0, three back-to-back offers → two accepted, in_ready = 0 on the third. Release grant → results appear in order, one per cycle, and the third is then accepted.
- Flush / reset: RoB_clear with both stages full → cdb_valid = 0 next cycle. rst_in low mid-stream → outputs zero immediately, in_ready = 1.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: shared encodings and result record for the integer execute unit
//   ROB_BITS  default RoB tag width
//   CLS_*     operation class codes held in in_op[1:0]
//   F3_*      funct3 codes for ALU and branch operations
//   res_t     combinational result of one operation (value, jump flags, redirect PC)
package alu_unit_pkg;
  localparam int ROB_BITS = 4;
  localparam logic [1:0] CLS_U = 2'd0, CLS_I = 2'd1, CLS_B = 2'd2, CLS_R = 2'd3;
  localparam logic [5:0] OP_JAL = 6'b111111;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
                         F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5,
                         F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  typedef struct packed {
    logic [31:0] value;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
  } res_t;
endpackage

// File: rtl/alu_unit_core.sv
// alu_core: combinational ALU / branch / jump evaluation of the EX-stage operation
//   op_i    {funct7 bit, funct3, class}; 6'b111111 is JAL
//   jalr_i  I-class operation is JALR
//   vj_i, vk_i, imm_i, pc_i  operands, immediate and instruction PC
//   res_o   rd value, is_jump, taken and redirect target
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic        jalr_i,
  input  logic [31:0] vj_i,
  input  logic [31:0] vk_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  output res_t        res_o
);
  logic [1:0] cls;
  logic [2:0] f3;
  logic f7, br;
  logic [31:0] b, alu, sra;
  assign cls = op_i[1:0];
  assign f3 = op_i[4:2];
  assign f7 = op_i[5];
  assign b = cls == CLS_R ? vk_i : imm_i;
  // kept in its own signal so the shift stays arithmetic (a mixed ternary would make it unsigned)
  assign sra = $signed(vj_i) >>> b[4:0];
  always_comb begin
    case (f3)
      F3_ADD:  alu = (cls == CLS_R && f7) ? vj_i - b : vj_i + b;
      F3_SLL:  alu = vj_i << b[4:0];
      F3_SLT:  alu = {31'd0, $signed(vj_i) < $signed(b)};
      F3_SLTU: alu = {31'd0, vj_i < b};
      F3_XOR:  alu = vj_i ^ b;
      F3_SR:   alu = f7 ? sra : vj_i >> b[4:0];
      F3_OR:   alu = vj_i | b;
      default: alu = vj_i & b;
    endcase
  end
  always_comb begin
    case (f3)
      F3_BEQ:  br = vj_i == vk_i;
      F3_BNE:  br = vj_i != vk_i;
      F3_BLT:  br = $signed(vj_i) < $signed(vk_i);
      F3_BGE:  br = $signed(vj_i) >= $signed(vk_i);
      F3_BLTU: br = vj_i < vk_i;
      F3_BGEU: br = vj_i >= vk_i;
      default: br = 1'b0;
    endcase
  end
  // JAL's encoding overlaps an R-class opcode, so it is recognised first
  always_comb begin
    res_o.value = alu;
    res_o.is_jump = 1'b0;
    res_o.taken = 1'b0;
    res_o.target = 32'd0;
    if (op_i == OP_JAL) begin
      res_o.value = pc_i + 32'd4;
      res_o.is_jump = 1'b1;
      res_o.taken = 1'b1;
      res_o.target = pc_i + imm_i;
    end else if (cls == CLS_I && jalr_i) begin
      res_o.value = pc_i + 32'd4;
      res_o.is_jump = 1'b1;
      res_o.taken = 1'b1;
      res_o.target = (vj_i + imm_i) & ~32'd1;
    end else if (cls == CLS_B) begin
      res_o.value = 32'd0;
      res_o.is_jump = 1'b1;
      res_o.taken = br;
      res_o.target = pc_i + imm_i;
    end else if (cls == CLS_U) begin
      res_o.value = imm_i;
    end
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: two-stage execute unit (EX operand latch, OUT result hold until CDB grant)
//   clk_in, rst_in (async active-low), rdy_in (global pause), RoB_clear (flush)
//   in_*      operation offered by the reservation station; alu_ack frees the RS entry
//   cdb_*     result broadcast, held stable until cdb_grant
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int RoB_BITS = ROB_BITS
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                RoB_clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_op,
  input  logic                in_jalr,
  input  logic [31:0]         in_vj,
  input  logic [31:0]         in_vk,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_pc,
  input  logic [RoB_BITS-1:0] in_dest,
  output logic                alu_ack,
  output logic                cdb_valid,
  input  logic                cdb_grant,
  output logic [RoB_BITS-1:0] cdb_dest,
  output logic [31:0]         cdb_value,
  output logic                cdb_is_jump,
  output logic                cdb_taken,
  output logic [31:0]         cdb_target
);
  logic ex_valid_q, ex_valid_d, out_valid_q, out_valid_d, grant_take, ex_move;
  logic [5:0] ex_op_q;
  logic ex_jalr_q;
  logic [31:0] ex_vj_q, ex_vk_q, ex_imm_q, ex_pc_q;
  logic [RoB_BITS-1:0] ex_dest_q, out_dest_q;
  res_t res, out_res_q;
  alu_core u_core (
    .op_i(ex_op_q), .jalr_i(ex_jalr_q), .vj_i(ex_vj_q), .vk_i(ex_vk_q),
    .imm_i(ex_imm_q), .pc_i(ex_pc_q), .res_o(res)
  );
  assign grant_take = cdb_grant && out_valid_q;
  assign ex_move = ex_valid_q && (!out_valid_q || grant_take);
  assign in_ready = !ex_valid_q || ex_move;
  assign alu_ack = in_valid && in_ready && rdy_in && !RoB_clear;
  assign ex_valid_d = RoB_clear ? 1'b0 : alu_ack ? 1'b1 : ex_move ? 1'b0 : ex_valid_q;
  assign out_valid_d = RoB_clear ? 1'b0 : ex_move ? 1'b1 : grant_take ? 1'b0 : out_valid_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ex_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      ex_op_q <= '0;
      ex_jalr_q <= 1'b0;
      ex_vj_q <= '0;
      ex_vk_q <= '0;
      ex_imm_q <= '0;
      ex_pc_q <= '0;
      ex_dest_q <= '0;
      out_dest_q <= '0;
      out_res_q <= '0;
    end else if (rdy_in) begin
      ex_valid_q <= ex_valid_d;
      out_valid_q <= out_valid_d;
      if (alu_ack) begin
        ex_op_q <= in_op;
        ex_jalr_q <= in_jalr;
        ex_vj_q <= in_vj;
        ex_vk_q <= in_vk;
        ex_imm_q <= in_imm;
        ex_pc_q <= in_pc;
        ex_dest_q <= in_dest;
      end
      if (ex_move) begin
        out_dest_q <= ex_dest_q;
        out_res_q <= res;
      end
    end
  end
  assign cdb_valid = out_valid_q;
  assign cdb_dest = out_dest_q;
  assign cdb_value = out_res_q.value;
  assign cdb_is_jump = out_res_q.is_jump;
  assign cdb_taken = out_res_q.taken;
  assign cdb_target = out_res_q.target;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against a reference model
module tb_alu_unit;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, RoB_clear = 1'b0, in_valid = 1'b0;
  logic in_ready, in_jalr = 1'b0, alu_ack, cdb_valid, cdb_grant = 1'b0, cdb_is_jump, cdb_taken;
  logic [5:0] in_op = '0;
  logic [31:0] in_vj = '0, in_vk = '0, in_imm = '0, in_pc = '0, cdb_value, cdb_target;
  logic [3:0] in_dest = '0, cdb_dest;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] value;
    logic is_jump;
    logic taken;
    logic [31:0] target;
    logic [3:0] dest;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic jalr;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0] dest;
    logic [31:0] value;
    logic is_jump, taken;
    logic [31:0] target;
  } vec_t;

  alu_unit #(.RoB_BITS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_jalr(in_jalr),
    .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc), .in_dest(in_dest),
    .alu_ack(alu_ack), .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_dest(cdb_dest),
    .cdb_value(cdb_value), .cdb_is_jump(cdb_is_jump), .cdb_taken(cdb_taken), .cdb_target(cdb_target)
  );

  always #5 clk_in = ~clk_in;

  // Reference: RISC-V semantics in plain integer arithmetic
  function automatic exp_t model(input logic [5:0] op, input logic jalr,
                                 input logic [31:0] a, input logic [31:0] k,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] dest);
    exp_t e;
    int cls, f3, sa, sb;
    int unsigned sh;
    logic [31:0] b;
    cls = int'(op[1:0]);
    f3 = int'(op[4:2]);
    e = '{32'd0, 1'b0, 1'b0, 32'd0, dest};
    b = (cls == 3) ? k : imm;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b) & 31;
    if (op == 6'h3f) e = '{pc + 32'd4, 1'b1, 1'b1, pc + imm, dest};
    else if (cls == 1 && jalr) e = '{pc + 32'd4, 1'b1, 1'b1, (a + imm) & 32'hFFFF_FFFE, dest};
    else if (cls == 2) begin
      e.is_jump = 1'b1;
      e.target = pc + imm;
      if (f3 == 0) e.taken = a == k;
      else if (f3 == 1) e.taken = a != k;
      else if (f3 == 4) e.taken = int'(a) < int'(k);
      else if (f3 == 5) e.taken = int'(a) >= int'(k);
      else if (f3 == 6) e.taken = a < k;
      else if (f3 == 7) e.taken = a >= k;
    end else if (cls == 0) e.value = imm;
    else begin
      if (f3 == 0) e.value = (cls == 3 && op[5]) ? a - b : a + b;
      else if (f3 == 1) e.value = a << sh;
      else if (f3 == 2) e.value = (sa < sb) ? 32'd1 : 32'd0;
      else if (f3 == 3) e.value = (a < b) ? 32'd1 : 32'd0;
      else if (f3 == 4) e.value = a ^ b;
      else if (f3 == 5) begin
        if (op[5]) e.value = 32'(sa >>> sh);
        else e.value = a >> sh;
      end else if (f3 == 6) e.value = a | b;
      else e.value = a & b;
    end
    return e;
  endfunction

  task automatic drive(input logic [5:0] op, input logic jalr, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [3:0] dest);
    in_valid = 1'b1;
    in_op = op;
    in_jalr = jalr;
    in_vj = vj;
    in_vk = vk;
    in_imm = imm;
    in_pc = pc;
    in_dest = dest;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_value !== 32'd0 || cdb_dest !== 4'd0 || cdb_is_jump !== 1'b0 ||
        cdb_taken !== 1'b0 || cdb_target !== 32'd0 || in_ready !== 1'b1 || alu_ack !== 1'b0)
      begin
        errors++;
        $display("FAIL reset: valid=%b value=%h dest=%h jump=%b taken=%b target=%h ready=%b ack=%b, required all 0 with ready=1",
                 cdb_valid, cdb_value, cdb_dest, cdb_is_jump, cdb_taken, cdb_target, in_ready, alu_ack);
      end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{6'b000011, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b0, 1'b0, 32'd0});
    v.push_back('{6'b100011, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd4, 32'h7FFF_FFFC, 1'b0, 1'b0, 32'd0});
    v.push_back('{6'b110111, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd5, 32'hF800_0000, 1'b0, 1'b0, 32'd0});
    v.push_back('{6'b010010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6, 32'd0, 1'b1, 1'b1, 32'h120});
    v.push_back('{6'b011010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd7, 32'd0, 1'b1, 1'b0, 32'h120});
    v.push_back('{6'b000001, 1'b1, 32'h1003, 32'd0, 32'd4, 32'h40, 4'd8, 32'h44, 1'b1, 1'b1, 32'h1006});
    v.push_back('{6'b111111, 1'b0, 32'd0, 32'd0, 32'h10, 32'h200, 4'd9, 32'h204, 1'b1, 1'b1, 32'h210});
    v.push_back('{6'b000000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h0, 4'd10, 32'h1234_5000, 1'b0, 1'b0, 32'd0});
    v.push_back('{6'b001001, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'd3, 32'h0, 4'd11, 32'd1, 1'b0, 1'b0, 32'd0});
    cdb_grant = 1'b1;
    foreach (v[i]) begin
      @(negedge clk_in);
      drive(v[i].op, v[i].jalr, v[i].vj, v[i].vk, v[i].imm, v[i].pc, v[i].dest);
      #1;
      checks++;
      if (alu_ack !== 1'b1) begin
        errors++;
        $display("FAIL directed_ack[%0d]: ack=%b required 1", i, alu_ack);
      end
      @(negedge clk_in);
      in_valid = 1'b0;
      @(negedge clk_in);
      #1;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_value !== v[i].value || cdb_dest !== v[i].dest ||
          cdb_is_jump !== v[i].is_jump || cdb_taken !== v[i].taken || cdb_target !== v[i].target) begin
        errors++;
        $display("FAIL directed[%0d]: got v=%b val=%h dst=%h j=%b t=%b tgt=%h, required v=1 val=%h dst=%h j=%b t=%b tgt=%h",
                 i, cdb_valid, cdb_value, cdb_dest, cdb_is_jump, cdb_taken, cdb_target,
                 v[i].value, v[i].dest, v[i].is_jump, v[i].taken, v[i].target);
      end
    end
    @(negedge clk_in);
  endtask

  task automatic test_backpressure();
    @(negedge clk_in);
    cdb_grant = 1'b0;
    drive(6'b000011, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
    #1;
    checks++;
    if (alu_ack !== 1'b1) begin errors++; $display("FAIL bp_ack_a: ack=%b required 1", alu_ack); end
    @(negedge clk_in);
    drive(6'b000011, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
    #1;
    checks++;
    if (alu_ack !== 1'b1) begin errors++; $display("FAIL bp_ack_b: ack=%b required 1", alu_ack); end
    @(negedge clk_in);
    drive(6'b000011, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 4'd3);
    #1;
    checks++;
    if (in_ready !== 1'b0 || alu_ack !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: ready=%b ack=%b required 0 0", in_ready, alu_ack);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (in_ready !== 1'b0 || cdb_valid !== 1'b1 || cdb_value !== 32'd2 || cdb_dest !== 4'd1) begin
      errors++;
      $display("FAIL bp_hold: ready=%b valid=%b val=%h dst=%h required 0 1 2 1", in_ready, cdb_valid, cdb_value, cdb_dest);
    end
    cdb_grant = 1'b1;
    #1;
    checks++;
    if (alu_ack !== 1'b1) begin errors++; $display("FAIL bp_release_ack: ack=%b required 1", alu_ack); end
    @(negedge clk_in);
    in_valid = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'd4 || cdb_dest !== 4'd2) begin
      errors++;
      $display("FAIL bp_second: valid=%b val=%h dst=%h required 1 4 2", cdb_valid, cdb_value, cdb_dest);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'd6 || cdb_dest !== 4'd3) begin
      errors++;
      $display("FAIL bp_third: valid=%b val=%h dst=%h required 1 6 3", cdb_valid, cdb_value, cdb_dest);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: valid=%b required 0", cdb_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk_in);
    cdb_grant = 1'b0;
    drive(6'b000011, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd4);
    @(negedge clk_in);
    drive(6'b000011, 1'b0, 32'd8, 32'd8, 32'd0, 32'd0, 4'd5);
    @(negedge clk_in);
    drive(6'b000011, 1'b0, 32'd7, 32'd7, 32'd0, 32'd0, 4'd6);
    RoB_clear = 1'b1;
    cdb_grant = 1'b1;
    #1;
    checks++;
    if (alu_ack !== 1'b0 || cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: ack=%b valid=%b required 0 1", alu_ack, cdb_valid);
    end
    @(negedge clk_in);
    RoB_clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: valid=%b ready=%b required 0 1", cdb_valid, in_ready);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: valid=%b required 0", cdb_valid); end
  endtask

  task automatic test_rdy_pause();
    @(negedge clk_in);
    cdb_grant = 1'b0;
    drive(6'b010011, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 4'd7);
    @(negedge clk_in);
    in_valid = 1'b0;
    @(negedge clk_in);
    rdy_in = 1'b0;
    cdb_grant = 1'b1;
    drive(6'b000011, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd8);
    #1;
    checks++;
    if (alu_ack !== 1'b0 || cdb_valid !== 1'b1 || cdb_value !== 32'hFF) begin
      errors++;
      $display("FAIL pause_ack: ack=%b valid=%b val=%h required 0 1 ff", alu_ack, cdb_valid, cdb_value);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'hFF || cdb_dest !== 4'd7) begin
      errors++;
      $display("FAIL pause_hold: valid=%b val=%h dst=%h required 1 ff 7", cdb_valid, cdb_value, cdb_dest);
    end
    rdy_in = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL pause_resume: valid=%b required 0", cdb_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_in);
    cdb_grant = 1'b0;
    drive(6'b000011, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd9);
    @(negedge clk_in);
    drive(6'b000011, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 4'd10);
    @(negedge clk_in);
    in_valid = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_value !== 32'd0 || cdb_dest !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b val=%h dst=%h ready=%b required 0 0 0 1", cdb_valid, cdb_value, cdb_dest, in_ready);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    cdb_grant = 1'b1;
    drive(6'b000011, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 4'd11);
    #1;
    checks++;
    if (alu_ack !== 1'b1) begin errors++; $display("FAIL reset_first_ack: ack=%b required 1", alu_ack); end
    @(negedge clk_in);
    in_valid = 1'b0;
    @(negedge clk_in);
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'd42 || cdb_dest !== 4'd11) begin
      errors++;
      $display("FAIL reset_first_result: valid=%b val=%h dst=%h required 1 2a b", cdb_valid, cdb_value, cdb_dest);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    logic [1:0] cls;
    logic [2:0] f3;
    logic f7;
    int cycles;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      cls = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      f7 = ((cls == 2'd3 || cls == 2'd1) && (f3 == 3'd0 || f3 == 3'd5)) ? 1'($urandom) : 1'b0;
      in_valid = ($urandom % 4) != 0;
      in_op = ($urandom % 8 == 0) ? 6'h3f : {f7, f3, cls};
      in_jalr = (cls == 2'd1) && ($urandom % 4 == 0);
      in_vj = $urandom;
      in_vk = ($urandom % 4 == 0) ? in_vj : $urandom;
      in_imm = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 63));
      in_pc = $urandom;
      in_dest = 4'($urandom);
      cdb_grant = ($urandom % 3) != 0;
      #1;
      if (cdb_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_spurious: valid=1 val=%h dst=%h, required no result pending", cdb_value, cdb_dest);
        end else if (cdb_value !== q[0].value || cdb_dest !== q[0].dest || cdb_is_jump !== q[0].is_jump ||
                     cdb_taken !== q[0].taken || cdb_target !== q[0].target) begin
          errors++;
          $display("FAIL random_result: got val=%h dst=%h j=%b t=%b tgt=%h, required val=%h dst=%h j=%b t=%b tgt=%h",
                   cdb_value, cdb_dest, cdb_is_jump, cdb_taken, cdb_target,
                   q[0].value, q[0].dest, q[0].is_jump, q[0].taken, q[0].target);
        end
        if (cdb_grant && q.size() != 0) void'(q.pop_front());
      end
      if (alu_ack) q.push_back(model(in_op, in_jalr, in_vj, in_vk, in_imm, in_pc, in_dest));
      checks++;
      if (q.size() > 2) begin
        errors++;
        $display("FAIL random_occupancy: in flight=%0d required at most 2", q.size());
      end
    end
    @(negedge clk_in);
    in_valid = 1'b0;
    cdb_grant = 1'b1;
    cycles = 0;
    while (q.size() != 0 && cycles < 10) begin
      #1;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_value !== q[0].value || cdb_dest !== q[0].dest || cdb_target !== q[0].target) begin
        errors++;
        $display("FAIL random_drain: valid=%b val=%h dst=%h, required 1 %h %h", cdb_valid, cdb_value, cdb_dest, q[0].value, q[0].dest);
      end
      if (cdb_valid) void'(q.pop_front());
      @(negedge clk_in);
      cycles++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL random_drain_timeout: pending=%0d required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_rdy_pause();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
